// File: rtl/spectrum_power_averager.sv
// spectrum_power_averager
// Per-bin power |X|^2 of the FFT output stream, summed over 2^k frames in a
// bin RAM, with a 2-cycle random-access read port for the register bank.
module spectrum_power_averager #(
    parameter int unsigned NFFT_LOG2    = 10,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned AVG_LOG2_MAX = 4,
    parameter int unsigned ACC_W        = 40
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [2*DATA_W-1:0]    s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic [2:0]             cfg_avg_log2,
    input  logic                   cfg_start,
    input  logic [NFFT_LOG2-1:0]   rd_addr,
    output logic [31:0]            rd_data,
    output logic                   busy,
    output logic                   done,
    output logic                   frame_err
);

    localparam int unsigned PROD_W  = 2 * DATA_W;
    localparam int unsigned PWR_W   = 2 * DATA_W + 1;
    localparam int unsigned FRAME_W = AVG_LOG2_MAX;
    localparam int unsigned DEPTH   = 1 << NFFT_LOG2;
    localparam int unsigned RD_W    = 32;
    localparam int unsigned K_W     = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Control state
    state_t                 r_state;
    logic [K_W-1:0]         r_k;
    logic [NFFT_LOG2-1:0]   r_bin;
    logic [FRAME_W-1:0]     r_frame;
    logic [1:0]             r_drain_cnt;

    // Pipeline stage S0 (squared components)
    logic                   r_s0_vld;
    logic [NFFT_LOG2-1:0]   r_s0_bin;
    logic                   r_s0_first;
    logic [PROD_W-1:0]      r_sq_re;
    logic [PROD_W-1:0]      r_sq_im;

    // Pipeline stage S1 (power and RAM read data)
    logic                   r_s1_vld;
    logic [NFFT_LOG2-1:0]   r_s1_bin;
    logic                   r_s1_first;
    logic [PWR_W-1:0]       r_pwr;

    // Bin RAM and its registered read data
    logic [ACC_W-1:0]       r_ram [DEPTH];
    logic [ACC_W-1:0]       r_ram_q;

    // Combinational helpers
    logic signed [DATA_W-1:0] w_re;
    logic signed [DATA_W-1:0] w_im;
    logic signed [PROD_W-1:0] w_sq_re;
    logic signed [PROD_W-1:0] w_sq_im;
    logic                     w_accept;
    logic                     w_bin_last;
    logic                     w_mismatch;
    logic                     w_take;
    logic [FRAME_W-1:0]       w_last_frame;
    logic                     w_frame_last;
    logic [K_W-1:0]           w_k_clamped;
    logic [NFFT_LOG2-1:0]     w_rd_sel;
    logic [ACC_W-1:0]         w_wr_data;
    logic [ACC_W-1:0]         w_shifted;
    logic [RD_W-1:0]          w_rd_sat;

    // Sample decode, frame-position checks and configuration clamp
    always_comb begin
        w_re         = s_axis_tdata[DATA_W-1:0];
        w_im         = s_axis_tdata[2*DATA_W-1:DATA_W];
        w_sq_re      = PROD_W'(w_re) * PROD_W'(w_re);
        w_sq_im      = PROD_W'(w_im) * PROD_W'(w_im);
        w_accept     = s_axis_tvalid && s_axis_tready;
        w_bin_last   = (r_bin == {NFFT_LOG2{1'b1}});
        w_mismatch   = w_accept && (s_axis_tlast != w_bin_last);
        w_take       = w_accept && !w_mismatch;
        w_last_frame = FRAME_W'((32'd1 << r_k) - 32'd1);
        w_frame_last = (r_frame == w_last_frame);
        w_k_clamped  = (cfg_avg_log2 > K_W'(AVG_LOG2_MAX)) ? K_W'(AVG_LOG2_MAX)
                                                           : cfg_avg_log2;
    end

    // Run control FSM: arms the stream, tracks bin/frame position, flags errors
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= S_IDLE;
            r_k           <= '0;
            r_bin         <= '0;
            r_frame       <= '0;
            r_drain_cnt   <= '0;
            s_axis_tready <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_state       <= S_ACCUM;
                        r_k           <= w_k_clamped;
                        r_bin         <= '0;
                        r_frame       <= '0;
                        done          <= 1'b0;
                        frame_err     <= 1'b0;
                        s_axis_tready <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (w_mismatch) begin
                        r_state       <= S_IDLE;
                        frame_err     <= 1'b1;
                        s_axis_tready <= 1'b0;
                        busy          <= 1'b0;
                    end else if (w_take) begin
                        r_bin <= r_bin + NFFT_LOG2'(1);
                        if (w_bin_last) begin
                            r_frame <= r_frame + FRAME_W'(1);
                            if (w_frame_last) begin
                                r_state       <= S_DRAIN;
                                r_drain_cnt   <= '0;
                                s_axis_tready <= 1'b0;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == 2'd2) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 2'd1;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    s_axis_tready <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

    // S0/S1 pipeline: square the components, then sum them into bin power
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_s0_vld   <= 1'b0;
            r_s0_bin   <= '0;
            r_s0_first <= 1'b0;
            r_sq_re    <= '0;
            r_sq_im    <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_bin   <= '0;
            r_s1_first <= 1'b0;
            r_pwr      <= '0;
        end else begin
            r_s0_vld <= w_take;
            if (w_take) begin
                r_s0_bin   <= r_bin;
                r_s0_first <= (r_frame == '0);
                r_sq_re    <= $unsigned(w_sq_re);
                r_sq_im    <= $unsigned(w_sq_im);
            end
            r_s1_vld <= r_s0_vld;
            if (r_s0_vld) begin
                r_s1_bin   <= r_s0_bin;
                r_s1_first <= r_s0_first;
                r_pwr      <= PWR_W'(r_sq_re) + PWR_W'(r_sq_im);
            end
        end
    end

    // Shared RAM read address: the write path owns it while a sample is in S0
    always_comb begin
        w_rd_sel  = r_s0_vld ? r_s0_bin : rd_addr;
        w_wr_data = r_s1_first ? ACC_W'(r_pwr) : (r_ram_q + ACC_W'(r_pwr));
    end

    // Bin RAM: one write port (S2 accumulate) and one registered read port
    always_ff @(posedge aclk) begin
        if (r_s1_vld) begin
            r_ram[r_s1_bin] <= w_wr_data;
        end
        r_ram_q <= r_ram[w_rd_sel];
    end

    // Average by shifting out k bits, saturating to the 32-bit read width
    always_comb begin
        w_shifted = r_ram_q >> r_k;
        w_rd_sat  = (|w_shifted[ACC_W-1:RD_W]) ? {RD_W{1'b1}} : w_shifted[RD_W-1:0];
    end

    // Read data register; forced to zero while a run owns the RAM
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_data <= '0;
        end else if (busy) begin
            rd_data <= '0;
        end else begin
            rd_data <= w_rd_sat;
        end
    end

endmodule

// File: tb/tb_spectrum_power_averager.sv
// Scoreboard bench for spectrum_power_averager (8-bin FFT configuration).
module tb_spectrum_power_averager;

    localparam int unsigned NFFT_LOG2 = 3;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned NB        = 1 << NFFT_LOG2;

    logic                  aclk = 1'b0;
    logic                  aresetn = 1'b0;
    logic [2*DATA_W-1:0]   s_axis_tdata = '0;
    logic                  s_axis_tvalid = 1'b0;
    logic                  s_axis_tready;
    logic                  s_axis_tlast = 1'b0;
    logic [2:0]            cfg_avg_log2 = '0;
    logic                  cfg_start = 1'b0;
    logic [NFFT_LOG2-1:0]  rd_addr = '0;
    logic [31:0]           rd_data;
    logic                  busy;
    logic                  done;
    logic                  frame_err;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] exp_q[$];
    logic rd_v0 = 1'b0;
    logic rd_v1 = 1'b0;
    logic rd_v2 = 1'b0;

    spectrum_power_averager #(
        .NFFT_LOG2(NFFT_LOG2), .DATA_W(DATA_W), .AVG_LOG2_MAX(4), .ACC_W(40)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .cfg_avg_log2(cfg_avg_log2), .cfg_start(cfg_start),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .frame_err(frame_err)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Read-valid tracker aligned to the 2-cycle read latency
    always @(posedge aclk) begin
        rd_v1 <= rd_v0;
        rd_v2 <= rd_v1;
    end

    // Monitor: pop and compare each read result as it emerges
    always @(negedge aclk) begin
        if (rd_v2) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL rd_data: result 0x%08h with empty scoreboard", rd_data);
            end else begin
                check("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic start(input int k);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        cfg_avg_log2  = 3'(k);
        cfg_start     = 1'b1;
        @(negedge aclk);
        cfg_start     = 1'b0;
    endtask

    task automatic send(input int re, input int im, input bit last);
        int n = 0;
        @(negedge aclk);
        s_axis_tdata  = {16'(im), 16'(re)};
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        while (!s_axis_tready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 50) begin
            n_vec++;
            n_miss++;
            $display("FAIL tready_timeout: got 0 expected 1");
        end
        @(posedge aclk);
    endtask

    task automatic idle();
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("done_wait", 32'(done), 32'd1);
    endtask

    // Issue back-to-back reads of every bin, expecting the same value table
    task automatic read_all(input logic [31:0] exp [NB]);
        for (int a = 0; a < int'(NB); a++) begin
            @(negedge aclk);
            rd_addr = NFFT_LOG2'(a);
            rd_v0   = 1'b1;
            exp_q.push_back(exp[a]);
        end
        @(negedge aclk);
        rd_v0 = 1'b0;
        repeat (3) @(negedge aclk);
    endtask

    // Single frame, k=0, re=n im=-n, with done-latency check
    task automatic run_t1();
        logic [31:0] e [NB];
        start(0);
        check("t1_done_clr", 32'(done), 32'd0);
        for (int n = 0; n < int'(NB); n++) begin
            send(n, -n, n == int'(NB) - 1);
            e[n] = 32'(2 * n * n);
        end
        idle();
        check("t1_busy_drain", 32'(busy), 32'd1);
        check("t1_tready_drop", 32'(s_axis_tready), 32'd0);
        check("t1_done_c1", 32'(done), 32'd0);
        repeat (2) @(negedge aclk);
        check("t1_done_c3m", 32'(done), 32'd0);
        @(negedge aclk);
        check("t1_done_c3", 32'(done), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);
        read_all(e);
    endtask

    initial begin
        logic [31:0] e25 [NB];
        logic [31:0] emax [NB];
        logic [31:0] ezero [NB];
        for (int i = 0; i < int'(NB); i++) begin
            e25[i]   = 32'd25;
            emax[i]  = 32'h8000_0000;
            ezero[i] = 32'd0;
        end

        // Reset state
        #12;
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_rd", rd_data, 32'd0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;

        // Test 1
        run_t1();

        // Test 2: k=2, 3+4j everywhere
        start(2);
        for (int f = 0; f < 4; f++)
            for (int b = 0; b < int'(NB); b++)
                send(3, 4, b == int'(NB) - 1);
        idle();
        wait_done();
        check("t2_ferr", 32'(frame_err), 32'd0);
        read_all(e25);

        // Test 3: most negative components
        start(0);
        for (int b = 0; b < int'(NB); b++)
            send(-32768, -32768, b == int'(NB) - 1);
        idle();
        wait_done();
        read_all(emax);

        // Test 4: tlast at bin 5
        start(1);
        for (int b = 0; b < 6; b++)
            send(1, 1, b == 5);
        idle();
        check("t4_ferr", 32'(frame_err), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_done", 32'(done), 32'd0);
        check("t4_tready", 32'(s_axis_tready), 32'd0);

        // Test 5: restart clears frame_err; gaps and a stray cfg_start
        start(2);
        check("t5_ferr_clr", 32'(frame_err), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        begin
            logic [31:0] e0 [NB];
            e0 = ezero;
            for (int a = 0; a < 1; a++) begin
                @(negedge aclk);
                rd_addr = '0;
                rd_v0   = 1'b1;
                exp_q.push_back(e0[0]);
            end
            @(negedge aclk);
            rd_v0 = 1'b0;
        end
        for (int f = 0; f < 4; f++) begin
            for (int b = 0; b < int'(NB); b++) begin
                send(3, 4, b == int'(NB) - 1);
                if (f == 1 && b == 4) start(0);
                repeat ($urandom_range(0, 2)) idle();
            end
        end
        idle();
        wait_done();
        check("t5_ferr", 32'(frame_err), 32'd0);
        read_all(e25);

        // Test 6: reset during frame 1 of a k=2 run, then rerun test 1
        start(2);
        for (int i = 0; i < int'(NB) + 3; i++)
            send(5, 5, i == int'(NB) - 1);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        check("t6_tready", 32'(s_axis_tready), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_ferr", 32'(frame_err), 32'd0);
        check("t6_rd", rd_data, 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        run_t1();

        repeat (4) @(negedge aclk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
